// File: rtl/teclado_pkg.sv
// Shared types and helpers for the lock keypad: digit buffer type, key
// constants, scan FSM states and the row/column to key-code mapping.
package teclado_pkg;

  localparam logic [3:0] KEY_STAR = 4'hA;
  localparam logic [3:0] KEY_HASH = 4'hB;
  localparam logic [3:0] KEY_NONE = 4'hF;

  // 20-nibble password buffer; digits[0] holds the newest key.
  typedef struct packed {
    logic [19:0][3:0] digits;
  } senhaPac_t;

  typedef enum logic [1:0] {
    ST_SCAN,
    ST_DEBOUNCE,
    ST_ACCEPT,
    ST_RELEASE
  } teclado_state_t;

  // True when exactly one active-low column line is asserted.
  function automatic logic one_cold(input logic [3:0] col);
    return (col == 4'b1110) || (col == 4'b1101) ||
           (col == 4'b1011) || (col == 4'b0111);
  endfunction

  // Active-low row drive pattern for a row index.
  function automatic logic [3:0] row_drive(input logic [1:0] row);
    return ~(4'b0001 << row);
  endfunction

  // Row/column to key code. Letter column (c=3) yields KEY_NONE.
  function automatic logic [3:0] key_map(input logic [1:0] row, input logic [3:0] col);
    logic [1:0] c;
    logic [3:0] code;
    case (col)
      4'b1101: c = 2'd1;
      4'b1011: c = 2'd2;
      4'b0111: c = 2'd3;
      default: c = 2'd0;
    endcase
    if (c == 2'd3)
      code = KEY_NONE;
    else if (row == 2'd3)
      code = (c == 2'd0) ? KEY_STAR : ((c == 2'd1) ? 4'h0 : KEY_HASH);
    else
      code = ({2'b00, row} * 4'd3) + {2'b00, c} + 4'd1;
    return code;
  endfunction

endpackage

// File: rtl/teclado_scan.sv
// Keypad matrix scanner: rotates the driven row, debounces a single-key
// press, and waits for a debounced release before resuming the scan.
// key_strobe is asserted combinationally in the last debounce cycle so the
// buffer owner can register the key on the edge that enters ACCEPT.
module teclado_scan
  import teclado_pkg::*;
#(
  parameter int SCAN_CYC     = 4,
  parameter int DEBOUNCE_CYC = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic [3:0] col_in,
  output logic [3:0] lin_out,
  output logic [3:0] key_code,
  output logic       key_strobe,
  output logic       scanning
);

  localparam int SC_W = $clog2(SCAN_CYC + 1);
  localparam int DB_W = $clog2(DEBOUNCE_CYC + 1);

  teclado_state_t    state;
  logic [1:0]        row;
  logic [3:0]        col_lat;
  logic [SC_W-1:0]   scan_cnt;
  logic [DB_W-1:0]   db_cnt;

  logic driving;
  logic match;
  logic db_last;

  assign driving    = (lin_out != 4'hF);
  assign match      = (col_in == col_lat);
  assign db_last    = (db_cnt == DB_W'(DEBOUNCE_CYC - 1));
  assign key_strobe = enable && (state == ST_DEBOUNCE) && match && db_last;
  assign key_code   = key_map(row, col_lat);
  assign scanning   = (state == ST_SCAN);

  // Scan / debounce / accept / release sequencing with registered row drive.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_SCAN;
      row      <= 2'd0;
      col_lat  <= 4'hF;
      scan_cnt <= '0;
      db_cnt   <= '0;
      lin_out  <= 4'b1110;
    end else if (!enable) begin
      state    <= ST_SCAN;
      row      <= 2'd0;
      col_lat  <= 4'hF;
      scan_cnt <= '0;
      db_cnt   <= '0;
      lin_out  <= 4'hF;
    end else begin
      case (state)
        ST_SCAN: begin
          if (!driving) begin
            // first enabled cycle after an abort: start driving row 0
            lin_out  <= row_drive(row);
            scan_cnt <= '0;
          end else if (one_cold(col_in)) begin
            col_lat  <= col_in;
            db_cnt   <= '0;
            scan_cnt <= '0;
            state    <= ST_DEBOUNCE;
          end else if (scan_cnt == SC_W'(SCAN_CYC - 1)) begin
            row      <= row + 2'd1;
            lin_out  <= row_drive(row + 2'd1);
            scan_cnt <= '0;
          end else begin
            scan_cnt <= scan_cnt + SC_W'(1);
          end
        end
        ST_DEBOUNCE: begin
          if (!match) begin
            db_cnt <= '0;
            state  <= ST_SCAN;
          end else if (db_last) begin
            db_cnt <= '0;
            state  <= ST_ACCEPT;
          end else begin
            db_cnt <= db_cnt + DB_W'(1);
          end
        end
        ST_ACCEPT: begin
          db_cnt <= '0;
          state  <= ST_RELEASE;
        end
        default: begin
          if (col_in != 4'hF) begin
            db_cnt <= '0;
          end else if (db_last) begin
            db_cnt   <= '0;
            scan_cnt <= '0;
            row      <= row + 2'd1;
            lin_out  <= row_drive(row + 2'd1);
            state    <= ST_SCAN;
          end else begin
            db_cnt <= db_cnt + DB_W'(1);
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/teclado_ctrl.sv
// Keypad controller top: owns the 20-nibble password buffer, the one-cycle
// digitos_valid pulse, terminator (* or #) clearing and enable gating.
// Optional idle timeout clear is built when TECLADO_TIMEOUT_EN is defined.
module teclado_ctrl
  import teclado_pkg::*;
#(
  parameter int SCAN_CYC     = 4,
  parameter int DEBOUNCE_CYC = 8,
  parameter int TIMEOUT_CYC  = 5000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic [3:0] col_in,
  output logic [3:0] lin_out,
  output senhaPac_t  digitos_value,
  output logic       digitos_valid
);

  logic [3:0] key_code;
  logic       key_strobe;
  logic       scan_idle;
  logic       accept;
  logic       term_pend;
  logic       timeout_hit;

  teclado_scan #(
    .SCAN_CYC     (SCAN_CYC),
    .DEBOUNCE_CYC (DEBOUNCE_CYC)
  ) u_scan (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .col_in     (col_in),
    .lin_out    (lin_out),
    .key_code   (key_code),
    .key_strobe (key_strobe),
    .scanning   (scan_idle)
  );

  // Letter keys strobe like any other key but never reach the buffer.
  assign accept = key_strobe && (key_code != KEY_NONE);

`ifdef TECLADO_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

  logic [TO_W-1:0] idle_cnt;
  logic            buf_loaded;

  assign buf_loaded  = (digitos_value.digits != '1);
  assign timeout_hit = scan_idle && buf_loaded && (idle_cnt == TO_W'(TIMEOUT_CYC - 1));

  // Idle counter: advances only while scanning with a partially typed code.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      idle_cnt <= '0;
    else if (!enable || key_strobe || !buf_loaded || timeout_hit)
      idle_cnt <= '0;
    else if (scan_idle)
      idle_cnt <= idle_cnt + TO_W'(1);
  end
`else
  logic timeout_unused;

  assign timeout_hit    = 1'b0;
  assign timeout_unused = (TIMEOUT_CYC != 0) & scan_idle;
`endif

  // Buffer update and pulse; a key accept takes priority over a timeout.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      digitos_value <= '1;
      digitos_valid <= 1'b0;
      term_pend     <= 1'b0;
    end else if (!enable) begin
      digitos_value <= '1;
      digitos_valid <= 1'b0;
      term_pend     <= 1'b0;
    end else if (accept) begin
      digitos_value.digits <= {digitos_value.digits[18:0], key_code};
      digitos_valid        <= 1'b1;
      term_pend            <= (key_code == KEY_STAR) || (key_code == KEY_HASH);
    end else begin
      digitos_valid <= 1'b0;
      term_pend     <= 1'b0;
      if (term_pend || timeout_hit)
        digitos_value <= '1;
    end
  end

endmodule

// File: tb/tb_teclado_ctrl.sv
// Self-checking bench for teclado_ctrl: a behavioural keypad matrix drives
// col_in from lin_out, and a queue model of typed digits predicts the buffer.
module tb_teclado_ctrl;
  import teclado_pkg::*;

  localparam int SC = 4;
  localparam int DB = 8;
  localparam int TO = 5000;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       enable = 1'b1;
  logic       pressed = 1'b0;
  logic [1:0] prow = 2'd0;
  logic [1:0] pcol = 2'd0;
  logic [3:0] col_force = 4'hF;
  logic [3:0] col_in;
  logic [3:0] lin_out;
  senhaPac_t  digitos_value;
  logic       digitos_valid;
  logic [79:0] val_now;

  int errors = 0;
  int checks = 0;

  // monitor state
  int cyc = 0;
  int pulses = 0;
  int last_cyc = 0;
  logic [79:0] last_val = '1;
  logic [79:0] post_val = '1;
  bit post_arm = 0;

  // reference model: typed codes, oldest first
  int mdl[$];
  int keymap[4][4] = '{'{1, 2, 3, 15}, '{4, 5, 6, 15}, '{7, 8, 9, 15}, '{10, 0, 11, 15}};
  int drow[10] = '{3, 0, 0, 0, 1, 1, 1, 2, 2, 2};
  int dcol[10] = '{1, 0, 1, 2, 0, 1, 2, 0, 1, 2};

  teclado_ctrl #(
    .SCAN_CYC     (SC),
    .DEBOUNCE_CYC (DB),
    .TIMEOUT_CYC  (TO)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .enable        (enable),
    .col_in        (col_in),
    .lin_out       (lin_out),
    .digitos_value (digitos_value),
    .digitos_valid (digitos_valid)
  );

  always #5 clk = ~clk;

  // Key matrix: a held key pulls its column low only while its row is driven.
  assign col_in  = ((pressed && !lin_out[prow]) ? ~(4'b0001 << pcol) : 4'hF) & col_force;
  assign val_now = digitos_value;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst) begin
      if (post_arm) begin
        post_val = val_now;
        post_arm = 0;
      end
      if (digitos_valid) begin
        pulses++;
        last_val = val_now;
        last_cyc = cyc;
        post_arm = 1;
      end
    end
  end

  function automatic logic [79:0] exp_val();
    logic [79:0] v;
    v = '1;
    for (int i = 0; i < mdl.size(); i++) v[4*i +: 4] = 4'(mdl[mdl.size()-1-i]);
    return v;
  endfunction

  function automatic void mdl_add(input int code);
    if (code != 15) begin
      mdl.push_back(code);
      if (mdl.size() > 20) void'(mdl.pop_front());
    end
  endfunction

  task automatic press(input int r, input int c, input int hold);
    prow = 2'(r);
    pcol = 2'(c);
    pressed = 1'b1;
    repeat (hold) @(negedge clk);
    pressed = 1'b0;
    repeat (2*DB + 8) @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if (lin_out !== 4'b1110) begin errors++; $display("FAIL reset_lin got %b want 1110", lin_out); end
    checks++;
    if (val_now !== {80{1'b1}}) begin errors++; $display("FAIL reset_buf got %h want all F", val_now); end
    checks++;
    if (digitos_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", digitos_valid); end
    rst = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_single_5();
    int p0;
    p0 = pulses;
    press(1, 1, 60);
    mdl_add(5);
    checks++;
    if (pulses !== p0 + 1) begin errors++; $display("FAIL key5_pulses got %0d want %0d", pulses - p0, 1); end
    checks++;
    if (last_val[3:0] !== 4'h5) begin errors++; $display("FAIL key5_digit0 got %h want 5", last_val[3:0]); end
    checks++;
    if (last_val[79:4] !== {76{1'b1}}) begin errors++; $display("FAIL key5_upper got %h want all F", last_val[79:4]); end
    checks++;
    if (val_now !== exp_val()) begin errors++; $display("FAIL key5_hold got %h want %h", val_now, exp_val()); end
  endtask

  task automatic test_sequence();
    int sr[5] = '{0, 0, 0, 1, 3};
    int sc[5] = '{0, 1, 2, 0, 0};
    int p0;
    p0 = pulses;
    for (int i = 0; i < 5; i++) begin
      press(sr[i], sc[i], 40);
      mdl_add(keymap[sr[i]][sc[i]]);
      checks++;
      if (last_val !== exp_val()) begin errors++; $display("FAIL seq_val%0d got %h want %h", i, last_val, exp_val()); end
    end
    checks++;
    if (pulses !== p0 + 5) begin errors++; $display("FAIL seq_pulses got %0d want 5", pulses - p0); end
    checks++;
    if (last_val[19:0] !== 20'h1234A) begin errors++; $display("FAIL seq_digits got %h want 1234a", last_val[19:0]); end
    checks++;
    if (post_val !== {80{1'b1}}) begin errors++; $display("FAIL seq_term_clear got %h want all F", post_val); end
    checks++;
    if (val_now !== {80{1'b1}}) begin errors++; $display("FAIL seq_after got %h want all F", val_now); end
    mdl.delete();
  endtask

  task automatic test_glitch();
    int p0;
    press(2, 1, 40);
    mdl_add(8);
    p0 = pulses;
    col_force = 4'b1110;
    repeat (3) @(negedge clk);
    col_force = 4'hF;
    repeat (30) @(negedge clk);
    checks++;
    if (pulses !== p0 || val_now !== exp_val()) begin
      errors++; $display("FAIL glitch got pulses=%0d val=%h want 0 and %h", pulses - p0, val_now, exp_val());
    end
    press(2, 3, 40);
    checks++;
    if (pulses !== p0 || val_now !== exp_val()) begin
      errors++; $display("FAIL key_C got pulses=%0d val=%h want 0 and %h", pulses - p0, val_now, exp_val());
    end
    col_force = 4'b1010;
    repeat (30) @(negedge clk);
    col_force = 4'hF;
    repeat (4) @(negedge clk);
    checks++;
    if (pulses !== p0 || val_now !== exp_val()) begin
      errors++; $display("FAIL multi_col got pulses=%0d val=%h want 0 and %h", pulses - p0, val_now, exp_val());
    end
  endtask

  task automatic test_wrap21();
    int p0;
    p0 = pulses;
    for (int k = 0; k < 21; k++) begin
      press(drow[k % 10], dcol[k % 10], 40);
      mdl_add(k % 10);
    end
    checks++;
    if (pulses !== p0 + 21) begin errors++; $display("FAIL wrap_pulses got %0d want 21", pulses - p0); end
    checks++;
    if (last_val !== exp_val()) begin errors++; $display("FAIL wrap_val got %h want %h", last_val, exp_val()); end
    checks++;
    if (last_val[3:0] !== 4'h0 || last_val[79:76] !== 4'h1) begin
      errors++; $display("FAIL wrap_ends got newest=%h oldest=%h want 0 and 1", last_val[3:0], last_val[79:76]);
    end
  endtask

  task automatic test_enable_drop();
    int p0;
    int n;
    p0 = pulses;
    prow = 2'd2; pcol = 2'd0; pressed = 1'b1;
    n = 0;
    while (lin_out !== 4'b1011 && n < 64) begin @(negedge clk); n++; end
    checks++;
    if (lin_out !== 4'b1011) begin errors++; $display("FAIL en_row2_wait got %b want 1011", lin_out); end
    repeat (3) @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    checks++;
    if (lin_out !== 4'b1111) begin errors++; $display("FAIL en_lin got %b want 1111", lin_out); end
    checks++;
    if (val_now !== {80{1'b1}}) begin errors++; $display("FAIL en_buf got %h want all F", val_now); end
    repeat (20) @(negedge clk);
    pressed = 1'b0;
    checks++;
    if (pulses !== p0 || lin_out !== 4'b1111) begin
      errors++; $display("FAIL en_idle got pulses=%0d lin=%b want 0 and 1111", pulses - p0, lin_out);
    end
    enable = 1'b1;
    @(negedge clk);
    checks++;
    if (lin_out !== 4'b1110) begin errors++; $display("FAIL en_resume got %b want 1110", lin_out); end
    mdl.delete();
    repeat (4) @(negedge clk);
  endtask

  task automatic test_random();
    int p0;
    int r;
    int c;
    int code;
    logic [79:0] v0;
    for (int k = 0; k < 25; k++) begin
      r = int'($urandom_range(0, 3));
      c = int'($urandom_range(0, 3));
      code = keymap[r][c];
      p0 = pulses;
      v0 = val_now;
      press(r, c, 40);
      checks++;
      if (code == 15) begin
        if (pulses !== p0 || val_now !== v0) begin
          errors++; $display("FAIL rnd_letter%0d got pulses=%0d val=%h want 0 and %h", k, pulses - p0, val_now, v0);
        end
      end else begin
        mdl_add(code);
        if (pulses !== p0 + 1 || last_val !== exp_val()) begin
          errors++; $display("FAIL rnd_key%0d got pulses=%0d val=%h want 1 and %h", k, pulses - p0, last_val, exp_val());
        end
        if (code == 10 || code == 11) begin
          checks++;
          if (post_val !== {80{1'b1}}) begin errors++; $display("FAIL rnd_term%0d got %h want all F", k, post_val); end
          mdl.delete();
        end
      end
    end
  endtask

  task automatic test_timeout();
    int p0;
    press(0, 2, 40);
    mdl_add(3);
    p0 = pulses;
    repeat (TO + 50) @(negedge clk);
`ifdef TECLADO_TIMEOUT_EN
    mdl.delete();
    checks++;
    if (val_now !== {80{1'b1}} || pulses !== p0) begin
      errors++; $display("FAIL timeout_clear got val=%h pulses=%0d want all F and 0", val_now, pulses - p0);
    end
`else
    checks++;
    if (val_now !== exp_val() || pulses !== p0) begin
      errors++; $display("FAIL no_timeout got val=%h pulses=%0d want %h and 0", val_now, pulses - p0, exp_val());
    end
`endif
  endtask

  task automatic test_rst_mid_release();
    int p0;
    int n;
    p0 = pulses;
    prow = 2'd2; pcol = 2'd2; pressed = 1'b1;
    n = 0;
    while (pulses == p0 && n < 80) begin @(negedge clk); n++; end
    checks++;
    if (pulses !== p0 + 1) begin errors++; $display("FAIL rst_first9 got %0d pulses want 1", pulses - p0); end
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    checks++;
    if (lin_out !== 4'b1110 || val_now !== {80{1'b1}} || digitos_valid !== 1'b0) begin
      errors++; $display("FAIL rst_async got lin=%b val=%h vld=%b want 1110, all F, 0", lin_out, val_now, digitos_valid);
    end
    pressed = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    mdl.delete();
    repeat (4) @(negedge clk);
    p0 = pulses;
    press(2, 2, 40);
    mdl_add(9);
    checks++;
    if (pulses !== p0 + 1 || last_val !== exp_val()) begin
      errors++; $display("FAIL rst_fresh9 got pulses=%0d val=%h want 1 and %h", pulses - p0, last_val, exp_val());
    end
  endtask

  task automatic test_latency();
    int p0;
    int c0;
    int n;
    rst = 1'b0;
    prow = 2'd0; pcol = 2'd0; pressed = 1'b1;
    repeat (3) @(negedge clk);
    mdl.delete();
    p0 = pulses;
    c0 = cyc;
    rst = 1'b1;
    n = 0;
    while (pulses == p0 && n < 40) begin @(negedge clk); n++; end
    mdl_add(1);
    checks++;
    if (pulses == p0) begin
      errors++; $display("FAIL latency_wait got no pulse want pulse within 40 cycles");
    end else if (last_cyc !== c0 + DB + 1) begin
      errors++; $display("FAIL latency got %0d want %0d", last_cyc - c0, DB + 1);
    end
    checks++;
    if (last_val !== exp_val()) begin errors++; $display("FAIL latency_val got %h want %h", last_val, exp_val()); end
    pressed = 1'b0;
    repeat (2*DB + 8) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_single_5();
    test_sequence();
    test_glitch();
    test_wrap21();
    test_enable_drop();
    test_random();
    test_timeout();
    test_rst_mid_release();
    test_latency();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/teclado_ctrl.md
# teclado_ctrl

Keypad controller for the lock. Scans a 4x4 key matrix, debounces presses, and builds the shared `senhaPac_t` digit buffer. Issues one `digitos_valid` pulse per accepted key, which feeds both `operacional` and `setup`. Gated by `teclado_en` from `operacional`.

## Interface
- `SCAN_CYC`, default 4: cycles each row is driven while scanning.
- `DEBOUNCE_CYC`, default 8: consecutive stable cycles required to accept a press or a release.
- `TIMEOUT_CYC`, default 5000: idle cycles before the buffer is cleared (see Configuration).
- `clk`  in  1: system clock.
- `rst`  in  1: asynchronous reset, active-low.
- `enable`  in  1: `teclado_en` from `operacional`.
- `col_in`  in  4: matrix columns, active-low, pulled up.
- `lin_out`  out  4: matrix rows, active-low, one-hot-zero while scanning.
- `digitos_value`  out  `senhaPac_t`: 20-nibble buffer `.digits[19:0]`; newest digit in `[3:0]`.
- `digitos_valid`  out  1: one-cycle pulse, one per accepted key.

## Operation
- Reset values (`rst`=0): `lin_out`=4'b1110, `digitos_value`=all 1s (every nibble 0xF), `digitos_valid`=0, FSM in SCAN, all counters 0.
- Key map, row r / column c:
  - row0: 1 2 3 A
  - row1: 4 5 6 B
  - row2: 7 8 9 C
  - row3: * 0 # D
- Key codes: digits map to 0x0–0x9, `*`→0xA, `#`→0xB. Letter keys A–D are ignored: they are debounced and released but produce no pulse.
- FSM states:
  - SCAN: drive row r low. After `SCAN_CYC` cycles, rotate to row (r+1) mod 4. If exactly one `col_in` bit is low, latch row/col and go to DEBOUNCE.
  - DEBOUNCE: row held. Counter increments while `col_in` equals the latched value. On any mismatch, return to SCAN at the same row, counter=0. When counter reaches `DEBOUNCE_CYC`, go to ACCEPT.
  - ACCEPT: one cycle. For a valid code, shift buffer left by one nibble and insert the code at `[3:0]`, then pulse `digitos_valid`. Oldest nibble `[79:76]` is discarded. Go to RELEASE.
  - RELEASE: row held. Wait for `col_in`=4'b1111 for `DEBOUNCE_CYC` consecutive cycles (counter restarts on any low bit), then go to SCAN, continuing with the next row.
- Multiple low columns in SCAN are treated as no key and scanning continues. The same holds in DEBOUNCE, where it counts as a mismatch.
- Terminator: in the cycle after the pulse carrying 0xA or 0xB, the buffer is set to all 1s.
- `enable`=0: synchronous abort from any state. FSM returns to SCAN row0, `lin_out`=4'b1111, buffer is all 1s, no pulse is issued, and `col_in` is ignored. Scanning resumes at row0 in the cycle after `enable` returns to 1.
- Reset asserted mid-debounce or mid-buffer: all state returns to reset values immediately, with no pulse.

## Timing
- Press latency: the stable press is first sampled in SCAN at cycle T. `digitos_valid`=1 at cycle T+`DEBOUNCE_CYC`+1, with the updated buffer visible in the same cycle.
- `digitos_value` is registered. It changes only in the ACCEPT cycle, the post-terminator clear cycle, on timeout, or on `enable` drop.
- At most one pulse per physical press, regardless of hold time.
- Minimum spacing between pulses: 2·`DEBOUNCE_CYC`+2 cycles.
- Timeout and ACCEPT in the same cycle: ACCEPT wins and the idle counter restarts.

## Configuration
- `TECLADO_TIMEOUT_EN` defined:
  - Idle counter runs while the buffer holds at least one non-0xF nibble and FSM is in SCAN.
  - When it reaches `TIMEOUT_CYC`, the buffer is set to all 1s, with no pulse.
  - Counter resets on every ACCEPT.
- `TECLADO_TIMEOUT_EN` undefined: no idle counter. The buffer clears only on a terminator, `enable`=0, or reset. `TIMEOUT_CYC` is unused.

## Structure
- Shared package holds:
  - `senhaPac_t`;
  - key constants `KEY_STAR`=4'hA, `KEY_HASH`=4'hB, `KEY_NONE`=4'hF;
  - FSM state enum `teclado_state_t`.
- Sub-module `teclado_scan` handles row rotation, debounce and release tracking. It outputs `key_code[3:0]` and `key_strobe`.
- `teclado_ctrl` owns the buffer, terminator clear, timeout and enable gating.

## Test plan
- Press key "5" (row1/col1 low) for 20 cycles → exactly one pulse; `digits[0]`=5, `digits[19:1]`=0xF.
- Press 1,2,3,4 then `*` → last pulse shows `digits[4:0]`={1,2,3,4,A}; next cycle the buffer is all 1s.
- Column glitch low for 3 cycles with `DEBOUNCE_CYC`=8 → no pulse, `digitos_value` unchanged; same result for key C held 20 cycles.
- Press 21 digits (0..9 repeating) → after the 21st pulse, the first digit is gone and `digits[0]` equals the 21st key.
- `enable` dropped during DEBOUNCE of "7" → no pulse, `lin_out`=4'b1111, buffer all 1s. With `TECLADO_TIMEOUT_EN`: one digit then 5000 idle cycles → buffer all 1s, no pulse.
- `rst` pulsed low mid-RELEASE → outputs at reset values immediately; a fresh "9" press is accepted normally afterwards.
